// File: rtl/case_6_sdiv_pkg.sv
// Shared types and helpers for the case_6 sequential signed divider.
// Optional remainder output is controlled by the CASE6_SDIV_REM_EN macro.
package case_6_sdiv_pkg;

   localparam int W     = 12;
   localparam int CNT_W = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // |-2^(W-1)| wraps to 2^(W-1), which is still exact as a W-bit unsigned value
   function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
      return x[W-1] ? (~x + 1'b1) : x;
   endfunction

endpackage

// File: rtl/case_6_udiv_core.sv
// Unsigned radix-2 restoring divider core: one quotient bit per cycle after load.
// The remainder port only exists when CASE6_SDIV_REM_EN is defined.
module case_6_udiv_core
   import case_6_sdiv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [W-1:0]     dividend,
   input  logic [W-1:0]     divisor,
   output logic             busy,
   output logic             fin,
   output logic [W-1:0]     quo
`ifdef CASE6_SDIV_REM_EN
   ,
   output logic [W-1:0]     prem
`endif
);

`ifndef CASE6_SDIV_REM_EN
   logic [W-1:0] prem;
`endif

   logic [W-1:0]     dvs;
   logic [CNT_W-1:0] cnt;
   logic [W:0]       trial;
   logic             ge;
   logic [W-1:0]     diff;

   // Trial value is one bit wider so a zero divisor cannot make it wrap
   always_comb begin
      trial = {prem, quo[W-1]};
      ge    = (trial >= {1'b0, dvs});
      diff  = trial[W-1:0] - dvs;
   end

   assign fin = (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         prem <= '0;
         quo  <= '0;
         dvs  <= '0;
      end else if (load) begin
         busy <= 1'b1;
         cnt  <= CNT_W'(W - 1);
         prem <= '0;
         quo  <= dividend;
         dvs  <= divisor;
      end else if (busy) begin
         if (ge) begin
            prem <= diff;
            quo  <= {quo[W-2:0], 1'b1};
         end else begin
            prem <= trial[W-1:0];
            quo  <= {quo[W-2:0], 1'b0};
         end
         if (cnt == '0) begin
            busy <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/case_6_sdiv_12s_12s_12_seq.sv
// Sequential signed divider with C truncation semantics; 'rem' output exists
// only when CASE6_SDIV_REM_EN is defined.
module case_6_sdiv_12s_12s_12_seq
   import case_6_sdiv_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 12,
   parameter int din1_WIDTH = 12,
   parameter int dout_WIDTH = 12
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  start,
   output logic                  ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout
`ifdef CASE6_SDIV_REM_EN
   ,
   output logic [din0_WIDTH-1:0] rem
`endif
);

   if (dout_WIDTH != din0_WIDTH || din0_WIDTH != W || din1_WIDTH != W || ID < 0) begin : g_param_chk
      $error("case_6_sdiv: widths must all equal %0d", W);
   end

   // Handshake: an op is accepted on a rising edge where start && ready; done
   // then pulses for exactly one cycle and dout/rem hold until the next done.
   state_t       state;
   logic         sign_q;
   logic         load;
   logic         core_busy;
   logic         core_fin;
   logic [W-1:0] quo;
`ifdef CASE6_SDIV_REM_EN
   logic         sign_r;
   logic [W-1:0] prem;
`endif

   assign load = (state == IDLE) && start && ready;

   case_6_udiv_core u_core (
      .clk      (ap_clk),
      .rst      (ap_rst),
      .load     (load),
      .dividend (abs_w(din0)),
      .divisor  (abs_w(din1)),
      .busy     (core_busy),
      .fin      (core_fin),
      .quo      (quo)
`ifdef CASE6_SDIV_REM_EN
      ,
      .prem     (prem)
`endif
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         dout   <= '0;
         sign_q <= 1'b0;
`ifdef CASE6_SDIV_REM_EN
         sign_r <= 1'b0;
         rem    <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (load) begin
                  sign_q <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
`ifdef CASE6_SDIV_REM_EN
                  sign_r <= din0[din0_WIDTH-1];
`endif
                  ready  <= 1'b0;
                  state  <= CALC;
               end
            end
            CALC: begin
               // The core's last iteration happens on this same edge
               if (core_busy && core_fin) begin
                  state <= FIX;
               end
            end
            FIX: begin
               dout <= sign_q ? (~quo + 1'b1) : quo;
`ifdef CASE6_SDIV_REM_EN
               rem  <= sign_r ? (~prem + 1'b1) : prem;
`endif
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_case_6_sdiv_12s_12s_12_seq.sv
// Self-checking bench for the case_6 sequential signed divider (CASE6_SDIV_REM_EN aware).
module tb_case_6_sdiv_12s_12s_12_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        start  = 1'b0;
   logic        ready;
   logic [11:0] din0   = '0;
   logic [11:0] din1   = '0;
   logic        done;
   logic [11:0] dout;
`ifdef CASE6_SDIV_REM_EN
   logic [11:0] rem;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] exp_q[$];
   int          acc_q[$];

   case_6_sdiv_12s_12s_12_seq dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .start  (start),
      .ready  (ready),
      .din0   (din0),
      .din1   (din1),
      .done   (done),
      .dout   (dout)
`ifdef CASE6_SDIV_REM_EN
      ,
      .rem    (rem)
`endif
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // C semantics: truncating division; x/0 gives quotient magnitude all ones, rem = x
   function automatic void model(input logic [11:0] a, input logic [11:0] b,
                                 output logic [11:0] q, output logic [11:0] r);
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0) begin
         q = (sa < 0) ? 12'h001 : 12'hFFF;
         r = a;
      end else begin
         q = 12'(sa / sb);
         r = 12'(sa % sb);
      end
   endfunction

   // Called at a negedge; returns at a negedge with the block idle again
   task automatic do_op(input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] eq, input logic [11:0] er);
      int cyc;
      cyc = 0;
      while (!ready && cyc < 40) begin
         @(negedge ap_clk);
         cyc++;
      end
      check("ready_idle", 32'(ready), 32'd1);
      start = 1'b1;
      din0  = a;
      din1  = b;
      @(negedge ap_clk);
      start = 1'b0;
      din0  = 12'($urandom);
      din1  = 12'($urandom);
      cyc   = 1;
      while (!done && cyc < 40) begin
         @(negedge ap_clk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'd14);
      check("dout", 32'(dout), 32'(eq));
`ifdef CASE6_SDIV_REM_EN
      check("rem", 32'(rem), 32'(er));
`else
      if (er === 12'hxxx) $display("unexpected x remainder");
`endif
      @(negedge ap_clk);
      check("done_pulse", 32'(done), 32'd0);
      check("ready_after", 32'(ready), 32'd1);
      check("dout_hold", 32'(dout), 32'(eq));
   endtask

   task automatic do_rand(input logic [11:0] a, input logic [11:0] b);
      logic [11:0] q, r;
      model(a, b, q, r);
      do_op(a, b, q, r);
   endtask

   logic [11:0] dir_a [9] = '{12'd100, 12'hF9C, 12'd100, 12'hF9C, 12'h800, 12'h7FF, 12'd7, 12'd5, 12'hFFB};
   logic [11:0] dir_b [9] = '{12'd7, 12'd7, 12'hFF9, 12'hFF9, 12'hFFF, 12'd1, 12'hF9C, 12'd0, 12'd0};
   logic [11:0] dir_q [9] = '{12'h00E, 12'hFF2, 12'hFF2, 12'h00E, 12'h800, 12'h7FF, 12'h000, 12'hFFF, 12'h001};
   logic [11:0] dir_r [9] = '{12'h002, 12'hFFE, 12'h002, 12'hFFE, 12'h000, 12'h000, 12'h007, 12'h005, 12'hFFB};
   logic [11:0] edge_b [5] = '{12'h000, 12'h001, 12'hFFF, 12'h800, 12'h7FF};

   initial begin
      logic [11:0] q, r;
      logic [23:0] e;
      int          last_acc, t, guard;

      // Reset state
      repeat (3) @(negedge ap_clk);
      ap_rst = 1'b0;
      @(negedge ap_clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
`ifdef CASE6_SDIV_REM_EN
      check("rst_rem", 32'(rem), 32'd0);
`endif

      // Directed values and boundaries
      for (int i = 0; i < 9; i++) do_op(dir_a[i], dir_b[i], dir_q[i], dir_r[i]);

      // start held high with fresh operands every cycle
      last_acc = -1;
      start = 1'b1;
      for (t = 0; t < 75; t++) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               check("tput_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("tput_latency", 32'(t - acc_q.pop_front()), 32'd14);
               check("tput_dout", 32'(dout), 32'(e[23:12]));
`ifdef CASE6_SDIV_REM_EN
               check("tput_rem", 32'(rem), 32'(e[11:0]));
`endif
            end
         end
         din0 = 12'($urandom);
         din1 = 12'($urandom);
         if (ready) begin
            if (last_acc >= 0) check("tput_spacing", 32'(t - last_acc), 32'd15);
            last_acc = t;
            model(din0, din1, q, r);
            exp_q.push_back({q, r});
            acc_q.push_back(t);
         end
         @(negedge ap_clk);
      end
      start = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 40) begin
         if (done) begin
            e = exp_q.pop_front();
            check("drain_latency", 32'(t - acc_q.pop_front()), 32'd14);
            check("drain_dout", 32'(dout), 32'(e[23:12]));
         end
         @(negedge ap_clk);
         t++;
         guard++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge ap_clk);

      // Reset in the middle of a calculation
      start = 1'b1;
      din0  = 12'd100;
      din1  = 12'd7;
      @(negedge ap_clk);
      start = 1'b0;
      repeat (5) @(negedge ap_clk);
      ap_rst = 1'b1;
      @(negedge ap_clk);
      ap_rst = 1'b0;
      check("midrst_ready", 32'(ready), 32'd1);
      check("midrst_dout", 32'(dout), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      guard = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) guard++;
         @(negedge ap_clk);
      end
      check("midrst_no_done", 32'(guard), 32'd0);
      do_op(12'd100, 12'd7, 12'h00E, 12'h002);

      // Special divisors against random dividends
      for (int k = 0; k < 5; k++)
         for (int i = 0; i < 40; i++) do_rand(12'($urandom), edge_b[k]);

      // Fully random operands
      for (int i = 0; i < 3000; i++) do_rand(12'($urandom), 12'($urandom_range(0, 4095)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
